c2_adder_arbiter: RTL and testbench
===================================

# c2_adder_arbiter

Round-robin arbiter and sequencer that shares one combinational SIZE-bit C2-cell ripple adder among NREQ requesters. Sits between the requesting datapath units and the shared adder instance. It owns the adder's operand registers, captures the sum one cycle after issue, and returns it with a per-requester valid/ready handshake. One operation is in flight at a time.

## Interface
- NREQ, 4: number of requesters, 2..8.
- SIZE, 5: operand and sum width; must match the shared adder.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_a  in  NREQ*SIZE  packed operand A; requester i uses bits [i*SIZE +: SIZE].
- req_b  in  NREQ*SIZE  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot, one-cycle pulse; the operands of that requester are accepted this cycle.
- add_a  out  SIZE  registered operand A to the shared adder.
- add_b  out  SIZE  registered operand B to the shared adder.
- add_sum  in  SIZE  combinational sum from the shared adder.
- resp_valid  out  NREQ  one-hot result valid to the granted requester.
- resp_ready  in  NREQ  requester accepts the result.
- resp_sum  out  SIZE  registered result.
- resp_ovf  out  1  two's-complement overflow of the result (see Configuration).
- busy  out  1  high in every state except IDLE.

## Operation
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE, when any req_valid is set:
  - Pick the first set bit at or above ptr, wrapping modulo NREQ.
  - Pulse req_ready[g] for that requester g.
  - Load add_a and add_b from g's operands; store g.
  - Go to ISSUE.
- IDLE, when no req_valid is set: stay in IDLE; outputs hold.
- ISSUE: add_sum is settled. Capture resp_sum <= add_sum and the overflow bit. Go to RESP.
- RESP:
  - resp_valid[g] = 1.
  - When resp_ready[g] = 1: set ptr <= (g+1) mod NREQ and go to IDLE.
  - resp_ready bits other than g are ignored.
- Arithmetic is modulo 2^SIZE. With SIZE=5, 13+25 gives 6. The adder has no carry-in and no carry-out.
- A requester may drop req_valid before it is granted; no grant results. After req_ready it may drop req_valid or change its operands, because they are already latched.
- Requests that arrive during ISSUE or RESP wait. They are not lost as long as req_valid stays high.
- Reset values:
  - state = IDLE, ptr = 0.
  - add_a, add_b, resp_sum = 0.
  - req_ready, resp_valid = 0.
  - resp_ovf = 0, busy = 0.

## Timing
- Accept at cycle T, with req_ready[g] high during T.
- ISSUE is cycle T+1.
- resp_valid[g] first goes high at T+2.
- If resp_ready[g] is high at T+2, the next grant can occur at T+3. Peak throughput is one operation per 3 cycles.
- resp_valid and resp_sum stay stable until the handshake completes.
- add_a and add_b hold from T+1 until the next accept.
- Reset asserted in any state returns immediately to the reset values. An in-flight result is discarded and no response is issued for it.
- All outputs are registered except req_ready, which is decoded from state and the grant.

## Configuration
- C2ARB_OVF_EN defined:
  - resp_ovf = (add_a[SIZE-1] == add_b[SIZE-1]) && (add_sum[SIZE-1] != add_a[SIZE-1]).
  - It is captured in ISSUE alongside resp_sum.
- C2ARB_OVF_EN undefined: resp_ovf is tied to 0 and no overflow logic is built.

## Structure
- Package c2_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - default constants C2ARB_NREQ = 4 and C2ARB_SIZE = 5;
  - the width of the pointer/index, $clog2(NREQ).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, index and any flag.
- The top level holds the FSM, the operand, result and ptr registers, and the overflow logic.
- The shared adder is instantiated outside this block and connected through add_a, add_b and add_sum.

## Test plan
- Single request: req_valid=4'b0010, a=13, b=25.
  - req_ready=4'b0010 at T; resp_valid=4'b0010 at T+2 with resp_sum=6.
  - With resp_ready high, busy falls at T+3.
- Round robin: all four requesters held valid with distinct operands, resp_ready tied high.
  - Grants in order 0,1,2,3,0, spaced every 3 cycles.
- Backpressure: resp_ready low for 5 cycles in RESP.
  - resp_valid and resp_sum stay stable; no new req_ready pulse.
  - Release resp_ready: next grant occurs 1 cycle later.
- Reset mid-operation: assert rst low during ISSUE.
  - All outputs go to 0 and ptr=0.
  - After release, a pending request on requester 3 with requester 0 also valid is granted to 0.
- Overflow (SIZE=5, C2ARB_OVF_EN defined): 12+7 gives sum 19 (-13) with resp_ovf=1; -3+2 gives sum 31 (-1) with resp_ovf=0.
  - Without the macro, resp_ovf=0 in both cases.

Source files
------------

// File: rtl/c2_adder_arbiter_pkg.sv
// c2_arb_pkg: shared types and defaults for the c2_adder_arbiter slice.
// Optional feature macro used elsewhere in the slice: C2ARB_OVF_EN.
package c2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int C2ARB_NREQ = 4;
   localparam int C2ARB_SIZE = 5;

   // Width of the round-robin pointer / requester index for n requesters.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/c2_adder_arbiter_if.sv
// Requester, response and shared-adder signals of the c2_adder_arbiter.
// slave = the arbiter side, master = the requesters plus the shared adder.
interface c2_adder_arbiter_if
   import c2_arb_pkg::*;
   #(parameter int NREQ = C2ARB_NREQ,
     parameter int SIZE = C2ARB_SIZE);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SIZE-1:0] req_a;
   logic [NREQ*SIZE-1:0] req_b;
   logic [NREQ-1:0]      req_ready;
   logic [SIZE-1:0]      add_a;
   logic [SIZE-1:0]      add_b;
   logic [SIZE-1:0]      add_sum;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready;
   logic [SIZE-1:0]      resp_sum;
   logic                 resp_ovf;
   logic                 busy;

   modport slave (
      input  req_valid, req_a, req_b, add_sum, resp_ready,
      output req_ready, add_a, add_b, resp_valid, resp_sum, resp_ovf, busy
   );

   modport master (
      output req_valid, req_a, req_b, add_sum, resp_ready,
      input  req_ready, add_a, add_b, resp_valid, resp_sum, resp_ovf, busy
   );

endinterface

// File: rtl/c2_adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Chooses the first set request
// at or above ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx,
   output logic            any
);

   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   // Rotating a doubled copy right by ptr puts requester ptr at bit 0.
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [PW-1:0]     off;
   logic [PW:0]       wsum;

   assign dbl = {req, req} >> ptr;
   assign rot = dbl[NREQ-1:0];

   // Lowest set offset from ptr wins; index is mapped back modulo NREQ.
   always_comb begin
      any  = |req;
      off  = '0;
      gnt  = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (rot[k]) off = k[PW-1:0];
      end
      wsum = {1'b0, ptr} + {1'b0, off};
      if (wsum >= NREQ_W) wsum = wsum - NREQ_W;
      idx = wsum[PW-1:0];
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/c2_adder_arbiter.sv
// c2_adder_arbiter: round-robin sequencer sharing one external SIZE-bit
// adder among NREQ requesters, one operation in flight at a time.
// Optional feature: define C2ARB_OVF_EN to register two's-complement
// overflow on resp_ovf; otherwise resp_ovf is tied low.
module c2_adder_arbiter
   import c2_arb_pkg::*;
   #(parameter int NREQ = C2ARB_NREQ,
     parameter int SIZE = C2ARB_SIZE)
   (
   input  logic               clk,
   input  logic               rst,
   c2_adder_arbiter_if.slave  bus
   );

   localparam int          PW     = idx_w(NREQ);
   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   state_t               state;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        gsel;
   logic [NREQ-1:0]      gsel_oh;
   logic signed [SIZE-1:0] add_a_q;
   logic signed [SIZE-1:0] add_b_q;
   logic [SIZE-1:0]      sum_q;
   logic [NREQ-1:0]      rvld_q;
   logic                 busy_q;

   logic [NREQ-1:0]      gnt;
   logic [PW-1:0]        gidx;
   logic                 gany;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (gany)
   );

   // Pointer advance past the requester just served, wrapping at NREQ.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
      logic [PW:0] inc;
      inc = {1'b0, g} + 1'b1;
      return (inc == NREQ_W) ? '0 : inc[PW-1:0];
   endfunction

`ifdef C2ARB_OVF_EN
   logic ovf_q;

   // Same-sign operands producing an opposite-sign sum overflowed.
   function automatic logic ovf_of(input logic [SIZE-1:0] a,
                                   input logic [SIZE-1:0] b,
                                   input logic [SIZE-1:0] s);
      return (a[SIZE-1] == b[SIZE-1]) && (s[SIZE-1] != a[SIZE-1]);
   endfunction

   assign bus.resp_ovf = ovf_q;
`else
   assign bus.resp_ovf = 1'b0;
`endif

   // Grant is only offered from IDLE and never while reset is held.
   assign bus.req_ready  = (state == IDLE && rst) ? gnt : '0;
   assign bus.add_a      = add_a_q;
   assign bus.add_b      = add_b_q;
   assign bus.resp_valid = rvld_q;
   assign bus.resp_sum   = sum_q;
   assign bus.busy       = busy_q;

   // Accept -> issue to adder -> hold result until the requester takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gsel    <= '0;
         gsel_oh <= '0;
         add_a_q <= '0;
         add_b_q <= '0;
         sum_q   <= '0;
         rvld_q  <= '0;
         busy_q  <= 1'b0;
`ifdef C2ARB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gany) begin
                  add_a_q <= bus.req_a[gidx*SIZE +: SIZE];
                  add_b_q <= bus.req_b[gidx*SIZE +: SIZE];
                  gsel    <= gidx;
                  gsel_oh <= gnt;
                  busy_q  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               sum_q  <= bus.add_sum;
`ifdef C2ARB_OVF_EN
               ovf_q  <= ovf_of(add_a_q, add_b_q, bus.add_sum);
`endif
               rvld_q <= gsel_oh;
               state  <= RESP;
            end
            RESP: begin
               if (|(bus.resp_ready & gsel_oh)) begin
                  rvld_q <= '0;
                  ptr    <= next_ptr(gsel);
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_c2_adder_arbiter.sv
// Self-checking bench for c2_adder_arbiter (NREQ=4, SIZE=5) with an
// arithmetic reference model. Honors C2ARB_OVF_EN when defined.
module tb_c2_adder_arbiter;

   localparam int NREQ = 4;
   localparam int SIZE = 5;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   mptr  = 0;

   c2_adder_arbiter_if #(.NREQ(NREQ), .SIZE(SIZE)) bus ();

   c2_adder_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Shared adder outside the arbiter.
   assign bus.add_sum = bus.add_a + bus.add_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin reference: first valid requester at or above mptr.
   function automatic int pick(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) begin
         if (v[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic int sum_of(input int a, input int b);
      return (a + b) % (1 << SIZE);
   endfunction

   function automatic int ovf_of(input int a, input int b);
`ifdef C2ARB_OVF_EN
      int sa, sb, s;
      sa = (a >= (1 << (SIZE-1))) ? a - (1 << SIZE) : a;
      sb = (b >= (1 << (SIZE-1))) ? b - (1 << SIZE) : b;
      s  = sa + sb;
      return (s > (1 << (SIZE-1)) - 1 || s < -(1 << (SIZE-1))) ? 1 : 0;
`else
      return (a < 0 || b < 0) ? 1 : 0;
`endif
   endfunction

   // One transaction starting at a negedge with the arbiter idle.
   task automatic run_op(input logic [NREQ-1:0] v,
                         input logic [NREQ*SIZE-1:0] pa,
                         input logic [NREQ*SIZE-1:0] pb,
                         input int hold, input bit keep);
      int g;
      int ea, eb;
      logic [NREQ-1:0] oh;
      g = pick(v);
      bus.req_valid  = v;
      bus.req_a      = pa;
      bus.req_b      = pb;
      bus.resp_ready = '0;
      #1;
      if (g < 0) begin
         check("idle_rdy", 32'(bus.req_ready), 0);
         check("idle_busy", 32'(bus.busy), 0);
         @(negedge clk);
         #1;
         check("idle_stay_busy", 32'(bus.busy), 0);
         return;
      end
      oh = NREQ'(1 << g);
      ea = int'(pa[g*SIZE +: SIZE]);
      eb = int'(pb[g*SIZE +: SIZE]);
      check("accept_rdy", 32'(bus.req_ready), 32'(oh));
      check("accept_busy", 32'(bus.busy), 0);
      @(negedge clk);
      if (!keep) bus.req_valid = '0;
      bus.req_a = (NREQ*SIZE)'($urandom);
      bus.req_b = (NREQ*SIZE)'($urandom);
      #1;
      check("issue_rdy", 32'(bus.req_ready), 0);
      check("issue_busy", 32'(bus.busy), 1);
      check("issue_add_a", 32'(bus.add_a), 32'(ea));
      check("issue_add_b", 32'(bus.add_b), 32'(eb));
      check("issue_rvld", 32'(bus.resp_valid), 0);
      @(negedge clk);
      bus.req_valid = '1;
      for (int h = 0; h <= hold; h++) begin
         bus.resp_ready = (h == hold) ? '1 : (~oh & NREQ'($urandom));
         #1;
         check("resp_vld", 32'(bus.resp_valid), 32'(oh));
         check("resp_sum", 32'(bus.resp_sum), 32'(sum_of(ea, eb)));
         check("resp_ovf", 32'(bus.resp_ovf), 32'(ovf_of(ea, eb)));
         check("resp_rdy", 32'(bus.req_ready), 0);
         check("resp_busy", 32'(bus.busy), 1);
         @(negedge clk);
      end
      bus.resp_ready = '0;
      bus.req_valid  = '0;
      #1;
      check("done_busy", 32'(bus.busy), 0);
      check("done_rvld", 32'(bus.resp_valid), 0);
      check("done_add_a", 32'(bus.add_a), 32'(ea));
      mptr = (g + 1) % NREQ;
   endtask

   initial begin
      rst            = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rdy", 32'(bus.req_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_rvld", 32'(bus.resp_valid), 0);
      check("rst_sum", 32'(bus.resp_sum), 0);
      check("rst_ovf", 32'(bus.resp_ovf), 0);
      check("rst_add_a", 32'(bus.add_a), 0);
      check("rst_add_b", 32'(bus.add_b), 0);
      @(negedge clk);
      rst = 1'b1;

      // Single request: requester 1, 13 + 25 wraps to 6.
      run_op(4'b0010, {4{5'd13}}, {4{5'd25}}, 0, 1'b0);

      // Round robin with everyone valid: 2,3,0,1,2 from ptr=2.
      for (int i = 0; i < 5; i++)
         run_op(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd20, 5'd10, 5'd9, 5'd8}, 0, 1'b1);

      // Backpressure: five cycles without resp_ready on the granted bit.
      run_op(4'b0101, {4{5'd17}}, {4{5'd9}}, 5, 1'b0);
      run_op(4'b0000, '0, '0, 0, 1'b0);

      // Overflow cases.
      run_op(4'b1111, {4{5'd12}}, {4{5'd7}}, 0, 1'b0);
      run_op(4'b1111, {4{5'd29}}, {4{5'd2}}, 1, 1'b0);

      // Reset during ISSUE with ptr parked on a nonzero value.
      run_op(4'b0010, {4{5'd3}}, {4{5'd6}}, 0, 1'b0);
      bus.req_valid = 4'b0100;
      bus.req_a     = {4{5'd11}};
      bus.req_b     = {4{5'd5}};
      #1;
      check("pre_rst_rdy", 32'(bus.req_ready), 32'(4'b0100));
      @(negedge clk);
      bus.req_valid = 4'b1001;
      rst = 1'b0;
      #1;
      mptr = 0;
      check("mid_rst_rdy", 32'(bus.req_ready), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_add_a", 32'(bus.add_a), 0);
      check("mid_rst_add_b", 32'(bus.add_b), 0);
      check("mid_rst_rvld", 32'(bus.resp_valid), 0);
      check("mid_rst_sum", 32'(bus.resp_sum), 0);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      #1;
      check("post_rst_rvld", 32'(bus.resp_valid), 0);
      @(negedge clk);
      #1;
      check("post_rst_rvld2", 32'(bus.resp_valid), 0);
      run_op(4'b1001, {5'd7, 5'd1, 5'd1, 5'd14}, {5'd7, 5'd1, 5'd1, 5'd3}, 0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 30; i++)
         run_op(NREQ'($urandom_range(0, 15)), (NREQ*SIZE)'($urandom),
                (NREQ*SIZE)'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
